udp_tx_feeder: RTL and testbench

- Payload source for the MAC wrapper's UDP transmit interface.
- Drains a byte FIFO (1-cycle read latency) into UDP payloads:
  - raises the wrapper's start flag;
  - requests a send with a latched length;
  - waits for the payload-RAM request;
  - writes exactly that many bytes;
  - pulses the done flag.
- Runs in the GMII TX clock domain, between the application FIFO and the MAC wrapper.

---
 rtl/udp_tx_feeder.sv | 173 +++++++++++++++++
 tb/tb_udp_tx_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_feeder.sv
// Byte-FIFO to MAC-wrapper UDP payload feeder: latches a packet length, handshakes
// start/request/prep with the wrapper, streams the payload bytes and signals done.
module udp_tx_feeder #(
   parameter int unsigned MAX_LEN      = 1472,
   parameter int unsigned FLUSH_CYCLES = 125000,
   parameter int unsigned PREP_TIMEOUT = 1250000,
   parameter int unsigned GAP_CYCLES   = 64
) (
   input  logic        gmii_tx_clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [11:0] cfg_len,
   input  logic [11:0] src_count,
   output logic        src_rd_en,
   input  logic [7:0]  src_rdata,
   output logic        fs_udp_tx,
   output logic        fd_udp_tx,
   output logic [11:0] udp_tx_len,
   output logic        flag_udp_tx_req,
   input  logic        flag_udp_tx_prep,
   output logic        udp_txen,
   output logic [7:0]  udp_txd,
   output logic        busy,
   output logic [15:0] pkt_cnt,
   output logic        err_timeout
);

   localparam int unsigned LEN_W   = 12;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);
   localparam int unsigned TMO_W   = $clog2(PREP_TIMEOUT + 1);
   localparam int unsigned GAP_W   = ($clog2(GAP_CYCLES + 1) < 2) ? 2 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_REQ, S_PREP, S_WRITE, S_DRAIN, S_GAP, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [FLUSH_W-1:0] flush_q, flush_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [GAP_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   pkt_q, pkt_d;
   logic               err_q, err_d;
   logic               fs_q, fs_d, fd_q, fd_d, req_q, req_d, busy_q, busy_d;
   logic               rd_en_q, rd_en_d, rd_dly_q, rd_dly_d, txen_q, txen_d;
   logic [7:0]         txd_q, txd_d;
   logic [LEN_W-1:0]   lim;
   logic               permit;

   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         flush_q  <= '0;
         tmo_q    <= '0;
         cnt_q    <= '0;
         rd_cnt_q <= '0;
         len_q    <= '0;
         pkt_q    <= '0;
         err_q    <= 1'b0;
         fs_q     <= 1'b0;
         fd_q     <= 1'b0;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_dly_q <= 1'b0;
         txen_q   <= 1'b0;
         txd_q    <= '0;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
         rd_cnt_q <= rd_cnt_d;
         len_q    <= len_d;
         pkt_q    <= pkt_d;
         err_q    <= err_d;
         fs_q     <= fs_d;
         fd_q     <= fd_d;
         req_q    <= req_d;
         busy_q   <= busy_d;
         rd_en_q  <= rd_en_d;
         rd_dly_q <= rd_dly_d;
         txen_q   <= txen_d;
         txd_q    <= txd_d;
      end
   end

   // Next state; every timer defaults to zero so it restarts whenever its state is left.
   always_comb begin
      state_d  = state_q;
      flush_d  = '0;
      tmo_d    = '0;
      cnt_d    = '0;
      rd_cnt_d = '0;
      len_d    = len_q;
      pkt_d    = pkt_q;
      err_d    = err_q;
      lim      = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      permit   = enable && (cfg_len != '0);

      case (state_q)
         S_IDLE: begin
            if (permit) begin
               if (src_count >= lim) begin
                  len_d   = lim;
                  state_d = S_START;
               end else if (src_count != '0) begin
                  if (flush_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                     len_d   = src_count;
                     state_d = S_START;
                  end else begin
                     flush_d = flush_q + FLUSH_W'(1);
                  end
               end
            end
         end
         S_START: state_d = S_REQ;
         S_REQ:   state_d = S_PREP;
         S_PREP: begin
            if (flag_udp_tx_prep) begin
               state_d = S_WRITE;
            end else if (tmo_q == TMO_W'(PREP_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_WRITE: begin
            if (rd_cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
            else rd_cnt_d = rd_cnt_q + LEN_W'(1);
         end
         S_DRAIN: begin
            if (cnt_q == GAP_W'(1)) state_d = S_GAP;
            else cnt_d = cnt_q + GAP_W'(1);
         end
         S_GAP: begin
            if (cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = S_DONE;
               pkt_d   = pkt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q + GAP_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      fs_d     = state_d inside {S_START, S_REQ, S_PREP, S_WRITE, S_DRAIN, S_GAP};
      fd_d     = (state_d == S_DONE);
      req_d    = (state_d == S_REQ);
      busy_d   = (state_d != S_IDLE);
      rd_en_d  = (state_d == S_WRITE);
      rd_dly_d = rd_en_q;
      txen_d   = rd_dly_q;
      txd_d    = rd_dly_q ? src_rdata : txd_q;
   end

   assign src_rd_en       = rd_en_q;
   assign fs_udp_tx       = fs_q;
   assign fd_udp_tx       = fd_q;
   assign udp_tx_len      = len_q;
   assign flag_udp_tx_req = req_q;
   assign udp_txen        = txen_q;
   assign udp_txd         = txd_q;
   assign busy            = busy_q;
   assign pkt_cnt         = pkt_q;
   assign err_timeout     = err_q;

endmodule

// File: tb/tb_udp_tx_feeder.sv
// Bench for udp_tx_feeder: FIFO and MAC-prep models around the DUT, packet-level
// reference derived from the length/flush/timeout rules and a byte queue.
module tb_udp_tx_feeder;

   localparam int MAX_LEN = 1472;
   localparam int FLUSH   = 50;
   localparam int PREP_TO = 100;
   localparam int GAP     = 16;

   logic        gmii_tx_clk, rst_n, enable, flag_udp_tx_prep;
   logic [11:0] cfg_len, src_count, udp_tx_len;
   logic        src_rd_en, fs_udp_tx, fd_udp_tx, flag_udp_tx_req, udp_txen, busy, err_timeout;
   logic [7:0]  src_rdata, udp_txd;
   logic [15:0] pkt_cnt;

   udp_tx_feeder #(
      .MAX_LEN(MAX_LEN), .FLUSH_CYCLES(FLUSH), .PREP_TIMEOUT(PREP_TO), .GAP_CYCLES(GAP)
   ) dut (
      .gmii_tx_clk(gmii_tx_clk), .rst_n(rst_n), .enable(enable), .cfg_len(cfg_len),
      .src_count(src_count), .src_rd_en(src_rd_en), .src_rdata(src_rdata),
      .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx), .udp_tx_len(udp_tx_len),
      .flag_udp_tx_req(flag_udp_tx_req), .flag_udp_tx_prep(flag_udp_tx_prep),
      .udp_txen(udp_txen), .udp_txd(udp_txd), .busy(busy), .pkt_cnt(pkt_cnt),
      .err_timeout(err_timeout)
   );

   int checks = 0, errors = 0;
   int cyc = 0;
   logic [7:0] fifo_mem [0:4095];
   int wr_ptr = 0, rd_ptr = 0;
   logic [7:0] ref_q[$];
   logic [7:0] got_q[$];
   int rd_total = 0, req_total = 0, run_total = 0, fd_total = 0, last_rd_cyc = 0;
   bit txen_prev = 0;
   int prep_delay = 0, prep_cnt = 0;
   int exp_pkt = 0;
   bit exp_err = 0;

   initial begin
      gmii_tx_clk = 1'b0;
      forever #5 gmii_tx_clk = ~gmii_tx_clk;
   end

   always @(posedge gmii_tx_clk) cyc <= cyc + 1;

   // FIFO with one-cycle read latency
   assign src_count = 12'(wr_ptr - rd_ptr);
   always @(posedge gmii_tx_clk) begin
      if (src_rd_en) begin
         src_rdata <= fifo_mem[rd_ptr % 4096];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // MAC side: raise prep prep_delay cycles after the request, hold until done
   always @(negedge gmii_tx_clk) begin
      if (!rst_n || fd_udp_tx) begin
         flag_udp_tx_prep = 1'b0;
         prep_cnt = 0;
      end else if (flag_udp_tx_req && prep_delay > 0) begin
         prep_cnt = prep_delay;
      end else if (prep_cnt > 0) begin
         prep_cnt--;
         if (prep_cnt == 0) flag_udp_tx_prep = 1'b1;
      end
   end

   always @(negedge gmii_tx_clk) begin
      if (udp_txen) got_q.push_back(udp_txd);
      if (udp_txen && !txen_prev) run_total++;
      txen_prev = udp_txen;
      if (src_rd_en) begin
         rd_total++;
         last_rd_cyc = cyc;
      end
      if (flag_udp_tx_req) req_total++;
      if (fd_udp_tx) fd_total++;
   end

   task automatic tick();
      @(posedge gmii_tx_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int n, input bit seq);
      for (int i = 0; i < n; i++) begin
         logic [7:0] b;
         b = seq ? 8'(i) : 8'($urandom);
         fifo_mem[wr_ptr % 4096] = b;
         wr_ptr++;
         ref_q.push_back(b);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {21'd0, fs_udp_tx, fd_udp_tx, udp_tx_len, flag_udp_tx_req, src_rd_en,
              udp_txen, udp_txd, busy, pkt_cnt, err_timeout};
   endfunction

   // One packet from enable-rise to done, checked against the rule-derived expectation.
   task automatic run_pkt(input int cfg, input int d, input bit tmo, input string tag);
      int lim, exp_len, e, st, fdc, rd0, req0, run0, base, mism;
      bit flush, found;
      lim     = (cfg > MAX_LEN) ? MAX_LEN : cfg;
      flush   = (ref_q.size() < lim);
      exp_len = flush ? ref_q.size() : lim;
      rd0 = rd_total; req0 = req_total; run0 = run_total; base = got_q.size();
      prep_delay = tmo ? 0 : d;
      cfg_len = 12'(cfg);
      enable  = 1'b1;
      e = cyc;
      found = 0;
      for (int i = 0; i < FLUSH + 20; i++) begin
         tick();
         if (fs_udp_tx) begin found = 1; break; end
      end
      chk({tag, "_start"}, 64'(found), 64'd1);
      if (!found) begin enable = 1'b0; return; end
      st = cyc;
      chk({tag, "_start_delay"}, 64'(st - e), 64'(flush ? FLUSH : 1));
      chk({tag, "_len"}, 64'(udp_tx_len), 64'(exp_len));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      cfg_len = 12'($urandom);
      found = 0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (fd_udp_tx) begin found = 1; break; end
      end
      enable = 1'b0;
      chk({tag, "_done"}, 64'(found), 64'd1);
      if (!found) return;
      fdc = cyc;
      chk({tag, "_req"}, 64'(req_total - req0), 64'd1);
      chk({tag, "_fs_at_done"}, 64'(fs_udp_tx), 64'd0);
      if (tmo) begin
         exp_err = 1;
         chk({tag, "_err"}, 64'(err_timeout), 64'd1);
         chk({tag, "_rd"}, 64'(rd_total - rd0), 64'd0);
         chk({tag, "_tx"}, 64'(got_q.size() - base), 64'd0);
         chk({tag, "_pkt"}, 64'(pkt_cnt), 64'(exp_pkt));
         chk({tag, "_dur"}, 64'(fdc - st + 1), 64'(PREP_TO + 3));
      end else begin
         exp_pkt = (exp_pkt + 1) % 65536;
         chk({tag, "_pkt"}, 64'(pkt_cnt), 64'(exp_pkt));
         chk({tag, "_err"}, 64'(err_timeout), 64'(exp_err));
         chk({tag, "_rd"}, 64'(rd_total - rd0), 64'(exp_len));
         chk({tag, "_ntx"}, 64'(got_q.size() - base), 64'(exp_len));
         chk({tag, "_runs"}, 64'(run_total - run0), 64'd1);
         chk({tag, "_fd_gap"}, 64'(fdc - last_rd_cyc), 64'(GAP + 3));
         chk({tag, "_dur"}, 64'(fdc - st + 1), 64'(1 + 1 + d + exp_len + 2 + GAP + 1));
         mism = 0;
         if (got_q.size() - base == exp_len) begin
            for (int i = 0; i < exp_len; i++)
               if (got_q[base + i] !== ref_q[i]) mism++;
         end else begin
            mism = -1;
         end
         chk({tag, "_data"}, 64'(mism), 64'd0);
         for (int i = 0; i < exp_len; i++) void'(ref_q.pop_front());
      end
      tick();
      chk({tag, "_idle_after"}, 64'({busy, fs_udp_tx, fd_udp_tx}), 64'd0);
   endtask

   initial begin
      int n, bad, fd0;
      rst_n = 1'b0; enable = 1'b0; cfg_len = '0;
      repeat (3) tick();
      chk("reset_outputs", all_outs(), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_after_reset", 64'({busy, src_rd_en}), 64'd0);

      push(16, 1'b1);
      run_pkt(16, 3, 1'b0, "basic16");

      push(1500, 1'b0);
      run_pkt(2000, int'($urandom_range(5, 1)), 1'b0, "clamp");
      chk("clamp_left", 64'(src_count), 64'd28);
      run_pkt(28, 1, 1'b0, "exact28");

      push(5, 1'b0);
      run_pkt(100, 2, 1'b0, "flush5");

      push(8, 1'b0);
      run_pkt(8, 0, 1'b1, "timeout");
      run_pkt(8, int'($urandom_range(6, 1)), 1'b0, "after_to");

      // Reset in the middle of a 16-byte write, after seven FIFO reads
      push(16, 1'b1);
      prep_delay = 1; cfg_len = 12'd16; enable = 1'b1;
      n = 0;
      for (int i = 0; i < 200 && n < 7; i++) begin
         tick();
         if (src_rd_en) n++;
      end
      chk("rst_reached_write", 64'(n), 64'd7);
      tick();
      fd0 = fd_total;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", all_outs(), 64'd0);
      repeat (3) tick();
      chk("rst_no_fd", 64'(fd_total - fd0), 64'd0);
      chk("rst_fifo_left", 64'(src_count), 64'd9);
      enable = 1'b0;
      rst_n = 1'b1;
      exp_pkt = 0; exp_err = 0;
      for (int i = 0; i < 7; i++) void'(ref_q.pop_front());
      repeat (2) tick();
      run_pkt(16, 2, 1'b0, "rst_flush");

      // No start while disabled or with zero length
      push(100, 1'b0);
      bad = 0;
      cfg_len = 12'd16; enable = 1'b0;
      for (int i = 0; i < 10 * FLUSH; i++) begin
         tick();
         if (fs_udp_tx || src_rd_en || busy) bad++;
      end
      chk("disabled_quiet", 64'(bad), 64'd0);
      cfg_len = 12'd0; enable = 1'b1;
      for (int i = 0; i < 10 * FLUSH; i++) begin
         tick();
         if (fs_udp_tx || src_rd_en || busy) bad++;
      end
      enable = 1'b0;
      chk("zero_len_quiet", 64'(bad), 64'd0);

      for (int k = 0; k < 6; k++) begin
         if (ref_q.size() == 0) push(int'($urandom_range(30, 1)), 1'b0);
         run_pkt(int'($urandom_range(120, 1)), int'($urandom_range(6, 1)), 1'b0, "rand");
         push(int'($urandom_range(40, 0)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
